// File: rtl/regfile_wb_arbiter_if.sv
// Signal bundle for regfile_wb_arbiter: two write-back request ports, the register-file
// write port, and the read-side busy/forward outputs for rs1/rs2.
interface regfile_wb_arbiter_if;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_rd, req1_rd;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_din;
  logic [4:0]  rs1, rs2;
  logic        rs1_busy, rs2_busy;
  logic        fwd_rs1_valid, fwd_rs2_valid;
  logic [31:0] fwd_rs1_data, fwd_rs2_data;

  modport master (
    output req0_valid, req0_rd, req0_data, req1_valid, req1_rd, req1_data, rs1, rs2,
    input  req0_ready, req1_ready, rf_we, rf_rd, rf_din, rs1_busy, rs2_busy,
           fwd_rs1_valid, fwd_rs2_valid, fwd_rs1_data, fwd_rs2_data
  );

  modport slave (
    input  req0_valid, req0_rd, req0_data, req1_valid, req1_rd, req1_data, rs1, rs2,
    output req0_ready, req1_ready, rf_we, rf_rd, rf_din, rs1_busy, rs2_busy,
           fwd_rs1_valid, fwd_rs2_valid, fwd_rs1_data, fwd_rs2_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter: two DEPTH-entry queues drain one write per cycle (min 1 cycle),
// ready drops only when a queue is full; define WB_FORWARD_EN to forward pending data to rs1/rs2.
module regfile_wb_arbiter #(
  parameter int DEPTH = 2
) (
  input logic               clk,
  input logic               reset,
  regfile_wb_arbiter_if.slave wb
);
  localparam int AW = $clog2(DEPTH);

  logic [4:0]    q_rd   [2][DEPTH];
  logic [31:0]   q_data [2][DEPTH];
  logic [AW-1:0] rptr   [2];
  logic [AW-1:0] wptr   [2];
  logic [AW:0]   count  [2];
  logic          last_grant;

  logic [1:0]    req_valid;
  logic [4:0]    req_rd   [2];
  logic [31:0]   req_data [2];
  logic [1:0]    ready, push, pop, nonempty;
  logic          gnt_vld, gnt_sel;

  always_comb begin
    req_valid   = {wb.req1_valid, wb.req0_valid};
    req_rd[0]   = wb.req0_rd;
    req_rd[1]   = wb.req1_rd;
    req_data[0] = wb.req0_data;
    req_data[1] = wb.req1_data;
    for (int n = 0; n < 2; n++) begin
      ready[n]    = (count[n] != (AW+1)'(DEPTH));
      nonempty[n] = (count[n] != '0);
      // Writes to x0 are accepted but never stored.
      push[n]     = req_valid[n] && ready[n] && (req_rd[n] != 5'd0);
    end
  end

  assign wb.req0_ready = ready[0];
  assign wb.req1_ready = ready[1];

  always_comb begin
    gnt_vld = 1'b0;
    gnt_sel = 1'b0;
    if (!reset) begin
      if (nonempty == 2'b11) begin
        gnt_vld = 1'b1;
        gnt_sel = ~last_grant;
      end else if (nonempty[0]) begin
        gnt_vld = 1'b1;
        gnt_sel = 1'b0;
      end else if (nonempty[1]) begin
        gnt_vld = 1'b1;
        gnt_sel = 1'b1;
      end
    end
  end

  assign pop[0]    = gnt_vld && !gnt_sel;
  assign pop[1]    = gnt_vld &&  gnt_sel;
  assign wb.rf_we  = gnt_vld;
  assign wb.rf_rd  = gnt_vld ? q_rd[gnt_sel][rptr[gnt_sel]]   : 5'd0;
  assign wb.rf_din = gnt_vld ? q_data[gnt_sel][rptr[gnt_sel]] : 32'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      for (int n = 0; n < 2; n++) begin
        rptr[n]  <= '0;
        wptr[n]  <= '0;
        count[n] <= '0;
      end
    end else begin
      if (gnt_vld) last_grant <= gnt_sel;
      for (int n = 0; n < 2; n++) begin
        if (push[n]) begin
          q_rd[n][wptr[n]]   <= req_rd[n];
          q_data[n][wptr[n]] <= req_data[n];
          wptr[n]            <= wptr[n] + AW'(1);
        end
        if (pop[n]) rptr[n] <= rptr[n] + AW'(1);
        count[n] <= count[n] + (AW+1)'(push[n]) - (AW+1)'(pop[n]);
      end
    end
  end

  // Scan each queue oldest-to-youngest so the last match seen is the youngest.
  logic [4:0]  rs   [2];
  logic [1:0]  hit  [2];
`ifdef WB_FORWARD_EN
  logic [31:0] fdat [2][2];
  logic [1:0]  fwd_vld;
`endif

  always_comb begin
    rs[0] = wb.rs1;
    rs[1] = wb.rs2;
    for (int s = 0; s < 2; s++) begin
      hit[s] = '0;
`ifdef WB_FORWARD_EN
      fdat[s][0] = '0;
      fdat[s][1] = '0;
`endif
      for (int n = 0; n < 2; n++) begin
        for (int k = 0; k < DEPTH; k++) begin
          logic [AW-1:0] idx;
          idx = rptr[n] + AW'(k);
          if ((k < int'(count[n])) && (q_rd[n][idx] == rs[s])) begin
            hit[s][n] = 1'b1;
`ifdef WB_FORWARD_EN
            fdat[s][n] = q_data[n][idx];
`endif
          end
        end
      end
    end
  end

  assign wb.rs1_busy = (rs[0] != 5'd0) && (|hit[0]);
  assign wb.rs2_busy = (rs[1] != 5'd0) && (|hit[1]);

`ifdef WB_FORWARD_EN
  // A match in both queues has no defined age order, so the consumer stalls on busy instead.
  always_comb begin
    for (int s = 0; s < 2; s++) fwd_vld[s] = (rs[s] != 5'd0) && (hit[s][0] ^ hit[s][1]);
  end
  assign wb.fwd_rs1_valid = fwd_vld[0];
  assign wb.fwd_rs2_valid = fwd_vld[1];
  assign wb.fwd_rs1_data  = fwd_vld[0] ? (hit[0][0] ? fdat[0][0] : fdat[0][1]) : 32'd0;
  assign wb.fwd_rs2_data  = fwd_vld[1] ? (hit[1][0] ? fdat[1][0] : fdat[1][1]) : 32'd0;
`else
  assign wb.fwd_rs1_valid = 1'b0;
  assign wb.fwd_rs2_valid = 1'b0;
  assign wb.fwd_rs1_data  = 32'd0;
  assign wb.fwd_rs2_data  = 32'd0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic against a queue-based
// reference model of the arbiter's write order, readiness, busy and forwarding rules.
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 2;
`ifdef WB_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  typedef struct packed { logic [4:0] rd; logic [31:0] data; } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  ent_t mq0[$];
  ent_t mq1[$];
  bit   m_last = 1'b1;

  regfile_wb_arbiter_if bus();
  regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .wb(bus));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int m_grant();
    if (reset) return -1;
    if (mq0.size() != 0 && mq1.size() != 0) return m_last ? 0 : 1;
    if (mq0.size() != 0) return 0;
    if (mq1.size() != 0) return 1;
    return -1;
  endfunction

  function automatic logic [37:0] exp_wr();
    int g = m_grant();
    if (g == 0) return {1'b1, mq0[0]};
    if (g == 1) return {1'b1, mq1[0]};
    return '0;
  endfunction

  function automatic logic [1:0] exp_ready();
    return {mq0.size() < DEPTH, mq1.size() < DEPTH};
  endfunction

  function automatic bit exp_busy(input logic [4:0] rs);
    bit b = 1'b0;
    foreach (mq0[i]) if (mq0[i].rd == rs) b = 1'b1;
    foreach (mq1[i]) if (mq1[i].rd == rs) b = 1'b1;
    return b && (rs != 5'd0);
  endfunction

  function automatic logic [32:0] exp_fwd(input logic [4:0] rs);
    bit m0 = 1'b0, m1 = 1'b0;
    logic [31:0] d0 = '0, d1 = '0;
    foreach (mq0[i]) if (mq0[i].rd == rs) begin m0 = 1'b1; d0 = mq0[i].data; end
    foreach (mq1[i]) if (mq1[i].rd == rs) begin m1 = 1'b1; d1 = mq1[i].data; end
    if (!FWD_EN || rs == 5'd0) return '0;
    if (m0 && !m1) return {1'b1, d0};
    if (m1 && !m0) return {1'b1, d1};
    return '0;
  endfunction

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    int g;
    bit a0, a1;
    @(posedge clk);
    g  = m_grant();
    a0 = bus.req0_valid && (mq0.size() < DEPTH);
    a1 = bus.req1_valid && (mq1.size() < DEPTH);
    if (reset) begin
      mq0.delete();
      mq1.delete();
      m_last = 1'b1;
    end else begin
      if (g == 0) begin void'(mq0.pop_front()); m_last = 1'b0; end
      if (g == 1) begin void'(mq1.pop_front()); m_last = 1'b1; end
      if (a0 && bus.req0_rd != 5'd0) mq0.push_back({bus.req0_rd, bus.req0_data});
      if (a1 && bus.req1_rd != 5'd0) mq1.push_back({bus.req1_rd, bus.req1_data});
    end
    #1;
  endtask

  task automatic drive(input bit v0, input logic [4:0] r0, input logic [31:0] d0,
                       input bit v1, input logic [4:0] r1, input logic [31:0] d1);
    bus.req0_valid = v0; bus.req0_rd = r0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_rd = r1; bus.req1_data = d1;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [37:0] wr;
    reset = 1'b1; bus.rs1 = 5'd0; bus.rs2 = 5'd0;
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick();
    wr = {bus.rf_we, bus.rf_rd, bus.rf_din};
    if (wr !== 38'd0) $display("FAIL reset_wr: got %h want 0", wr); else n_pass++;
    n_total++;
    reset = 1'b0; bus.rs1 = 5'd3; bus.rs2 = 5'd9;
    drive(0, 0, 0, 0, 0, 0);
    if ({bus.req0_ready, bus.req1_ready} !== 2'b11) $display("FAIL reset_ready: got %b want 11", {bus.req0_ready, bus.req1_ready}); else n_pass++;
    n_total++;
    if ({bus.rs1_busy, bus.rs2_busy, bus.fwd_rs1_valid, bus.fwd_rs2_valid} !== 4'b0000)
      $display("FAIL reset_busy_fwd: got %b want 0000", {bus.rs1_busy, bus.rs2_busy, bus.fwd_rs1_valid, bus.fwd_rs2_valid});
    else n_pass++;
    n_total++;
    drive(1, 5'd1, 32'h1111, 1, 5'd2, 32'h2222);
    tick();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    if (bus.rf_we !== 1'b0) $display("FAIL rst_force_we: got %b want 0", bus.rf_we); else n_pass++;
    n_total++;
    tick();
    reset = 1'b0; bus.rs1 = 5'd1; bus.rs2 = 5'd2;
    drive(0, 0, 0, 0, 0, 0);
    if ({bus.rf_we, bus.rs1_busy, bus.rs2_busy, bus.req0_ready, bus.req1_ready} !== 5'b00011)
      $display("FAIL rst_drop: got %b want 00011", {bus.rf_we, bus.rs1_busy, bus.rs2_busy, bus.req0_ready, bus.req1_ready});
    else n_pass++;
    n_total++;
  endtask

  task automatic test_single();
    logic [37:0] wr;
    bus.rs1 = 5'd5;
    drive(1, 5'd5, 32'hAAAA_0001, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    wr = {bus.rf_we, bus.rf_rd, bus.rf_din};
    if (wr !== {1'b1, 5'd5, 32'hAAAA_0001}) $display("FAIL single_wr: got %h want %h", wr, {1'b1, 5'd5, 32'hAAAA_0001}); else n_pass++;
    n_total++;
    if (bus.rs1_busy !== 1'b1) $display("FAIL single_busy: got %b want 1", bus.rs1_busy); else n_pass++;
    n_total++;
    tick();
    drive(0, 0, 0, 0, 0, 0);
    if ({bus.rs1_busy, bus.rf_we} !== 2'b00) $display("FAIL single_after: got %b want 00", {bus.rs1_busy, bus.rf_we}); else n_pass++;
    n_total++;
  endtask

  task automatic test_contention();
    logic [4:0] order [4];
    logic [1:0] rdy   [4];
    order[0] = 5'd1; order[1] = 5'd3; order[2] = 5'd2; order[3] = 5'd4;
    rdy[0] = 2'b11; rdy[1] = 2'b10; rdy[2] = 2'b11; rdy[3] = 2'b11;
    reset = 1'b1; drive(0, 0, 0, 0, 0, 0); tick();
    reset = 1'b0;
    drive(1, 5'd1, 32'h10, 1, 5'd3, 32'h30); tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drive(1, 5'd2, 32'h20, 1, 5'd4, 32'h40);
      else        drive(0, 0, 0, 0, 0, 0);
      if ({bus.rf_we, bus.rf_rd} !== {1'b1, order[i]}) $display("FAIL contention_order%0d: got %h want %h", i, {bus.rf_we, bus.rf_rd}, {1'b1, order[i]}); else n_pass++;
      n_total++;
      if ({bus.req0_ready, bus.req1_ready} !== rdy[i]) $display("FAIL contention_ready%0d: got %b want %b", i, {bus.req0_ready, bus.req1_ready}, rdy[i]); else n_pass++;
      n_total++;
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    if (bus.rf_we !== 1'b0) $display("FAIL contention_drained: got %b want 0", bus.rf_we); else n_pass++;
    n_total++;
  endtask

  task automatic test_x0();
    bus.rs1 = 5'd0;
    drive(0, 0, 0, 1, 5'd0, 32'hDEAD);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      if ({bus.rf_we, bus.rs1_busy, bus.req1_ready} !== 3'b001) $display("FAIL x0_discard%0d: got %b want 001", i, {bus.rf_we, bus.rs1_busy, bus.req1_ready}); else n_pass++;
      n_total++;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [37:0] wr;
    bus.rs1 = 5'd10;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) drive(1, 5'd10, 32'hB000 + i, 0, 0, 0);
      else       drive(0, 0, 0, 0, 0, 0);
      if (i < 8) begin
        if (bus.req0_ready !== 1'b1) $display("FAIL b2b_ready%0d: got %b want 1", i, bus.req0_ready); else n_pass++;
        n_total++;
      end
      if (i > 0) begin
        wr = {bus.rf_we, bus.rf_rd, bus.rf_din};
        if (wr !== {1'b1, 5'd10, 32'hB000 + 32'(i - 1)}) $display("FAIL b2b_wr%0d: got %h want %h", i, wr, {1'b1, 5'd10, 32'hB000 + 32'(i - 1)}); else n_pass++;
        n_total++;
        if (bus.rs1_busy !== 1'b1) $display("FAIL b2b_busy%0d: got %b want 1", i, bus.rs1_busy); else n_pass++;
        n_total++;
      end
      tick();
    end
  endtask

  task automatic test_forward();
    logic [32:0] fw;
    reset = 1'b1; drive(0, 0, 0, 0, 0, 0); tick();
    reset = 1'b0; bus.rs2 = 5'd7;
    drive(1, 5'd3, 32'h3, 0, 0, 0); tick();
    drive(1, 5'd7, 32'h11, 1, 5'd9, 32'h99); tick();
    drive(1, 5'd7, 32'h22, 0, 0, 0);
    if (bus.rf_rd !== 5'd9) $display("FAIL fwd_rr_grant: got %0d want 9", bus.rf_rd); else n_pass++;
    n_total++;
    tick();
    drive(0, 0, 0, 1, 5'd7, 32'h33);
    fw = {bus.fwd_rs2_valid, bus.fwd_rs2_data};
    if (fw !== (FWD_EN ? {1'b1, 32'h22} : 33'd0)) $display("FAIL fwd_youngest: got %h want %h", fw, FWD_EN ? {1'b1, 32'h22} : 33'd0); else n_pass++;
    n_total++;
    if ({bus.rs2_busy, bus.rf_din} !== {1'b1, 32'h11}) $display("FAIL fwd_busy_pop: got %h want %h", {bus.rs2_busy, bus.rf_din}, {1'b1, 32'h11}); else n_pass++;
    n_total++;
    tick();
    drive(0, 0, 0, 0, 0, 0);
    fw = {bus.fwd_rs2_valid, bus.fwd_rs2_data};
    if ({fw, bus.rs2_busy} !== {33'd0, 1'b1}) $display("FAIL fwd_both_queues: got %h want %h", {fw, bus.rs2_busy}, {33'd0, 1'b1}); else n_pass++;
    n_total++;
    tick(); tick();
  endtask

  task automatic test_random();
    logic [37:0] wr, ewr;
    logic [32:0] f1, f2, ef1, ef2;
    for (int c = 0; c < 500; c++) begin
      reset   = ($urandom_range(0, 59) == 0);
      bus.rs1 = 5'($urandom_range(0, 7));
      bus.rs2 = 5'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      wr = {bus.rf_we, bus.rf_rd, bus.rf_din}; ewr = exp_wr();
      if (wr !== ewr) $display("FAIL rand_wr c=%0d: got %h want %h", c, wr, ewr); else n_pass++;
      n_total++;
      if ({bus.req0_ready, bus.req1_ready} !== exp_ready()) $display("FAIL rand_ready c=%0d: got %b want %b", c, {bus.req0_ready, bus.req1_ready}, exp_ready()); else n_pass++;
      n_total++;
      if ({bus.rs1_busy, bus.rs2_busy} !== {exp_busy(bus.rs1), exp_busy(bus.rs2)})
        $display("FAIL rand_busy c=%0d: got %b want %b", c, {bus.rs1_busy, bus.rs2_busy}, {exp_busy(bus.rs1), exp_busy(bus.rs2)});
      else n_pass++;
      n_total++;
      f1 = {bus.fwd_rs1_valid, bus.fwd_rs1_data}; ef1 = exp_fwd(bus.rs1);
      f2 = {bus.fwd_rs2_valid, bus.fwd_rs2_data}; ef2 = exp_fwd(bus.rs2);
      if ({f1, f2} !== {ef1, ef2}) $display("FAIL rand_fwd c=%0d: got %h want %h", c, {f1, f2}, {ef1, ef2}); else n_pass++;
      n_total++;
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_x0();
    test_back_to_back();
    test_forward();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
